// File: rtl/instr_stream_encoder.sv
// Instruction stream encoder: packs symbolic RV32I requests into 32-bit words,
// buffers them in a small FIFO and writes them sequentially to instruction memory.
// Optional build macro: INSTR_ENC_ALIGN_CHECK_EN (drops misaligned branch/jal
// targets and any request while the write pointer is not word aligned).
module instr_stream_encoder #(
  parameter int unsigned       DEPTH     = 4,
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [3:0]               req_kind,
  input  logic [2:0]               req_funct3,
  input  logic                     req_funct7b5,
  input  logic [4:0]               req_rd,
  input  logic [4:0]               req_rs1,
  input  logic [4:0]               req_rs2,
  input  logic [31:0]              req_imm,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic                     mem_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              words_written,
  output logic                     err_illegal
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [3:0] K_BRANCH = 4'd3;
  localparam logic [3:0] K_JAL    = 4'd5;

  logic [31:0]       fifo_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       words_q, words_d;
  logic              err_q, err_d;

  logic [31:0] enc_c;
  logic        kind_ok_c;
  logic        align_bad_c;
  logic        legal_c;
  logic        full_c;
  logic        accept_c;
  logic        push_c;
  logic        pop_c;

  // Combinational RV32I packing of the request fields
  always_comb begin
    enc_c     = '0;
    kind_ok_c = 1'b1;
    unique case (req_kind)
      4'd0: enc_c = {req_imm[11:0], req_rs1, 3'b010, req_rd, OP_LOAD};
      4'd1: enc_c = {req_imm[11:5], req_rs2, req_rs1, 3'b010, req_imm[4:0], OP_STORE};
      4'd2: enc_c = {1'b0, req_funct7b5, 5'b00000, req_rs2, req_rs1, req_funct3, req_rd, OP_R};
      4'd3: enc_c = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                     req_imm[4:1], req_imm[11], OP_BRANCH};
      4'd4: begin
        if ((req_funct3 == 3'b001) || (req_funct3 == 3'b101)) begin
          enc_c = {1'b0, req_funct7b5, 5'b00000, req_imm[4:0], req_rs1, req_funct3, req_rd, OP_IALU};
        end else begin
          enc_c = {req_imm[11:0], req_rs1, req_funct3, req_rd, OP_IALU};
        end
      end
      4'd5: enc_c = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, OP_JAL};
      4'd6: enc_c = {req_imm[31:12], req_rd, OP_LUI};
      4'd7: enc_c = {req_imm[31:12], req_rd, OP_AUIPC};
      4'd8: enc_c = {req_imm[11:0], req_rs1, 3'b000, req_rd, OP_JALR};
      default: kind_ok_c = 1'b0;
    endcase
  end

`ifdef INSTR_ENC_ALIGN_CHECK_EN
  // Misaligned control-flow target or misaligned write pointer drops the request
  assign align_bad_c = (((req_kind == K_BRANCH) || (req_kind == K_JAL)) && req_imm[0])
                       || (addr_q[1:0] != 2'b00);
`else
  assign align_bad_c = 1'b0;
`endif

  assign legal_c  = kind_ok_c & ~align_bad_c;
  assign full_c   = (count_q == CNT_W'(DEPTH));
  assign accept_c = req_valid & ~full_c & ~clear;
  assign push_c   = accept_c & legal_c;
  assign pop_c    = (count_q != '0) & mem_ready & ~clear;

  // Next-state for pointers, occupancy, write address, counters and error flag
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    addr_d   = addr_q;
    words_d  = words_q;
    err_d    = err_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      addr_d   = BASE_ADDR;
      words_d  = '0;
      err_d    = 1'b0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        addr_d   = addr_q + ADDR_W'(4);
        if (words_q != 16'hFFFF) words_d = words_q + 16'd1;
      end
      unique case ({push_c, pop_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (accept_c && !legal_c) err_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= BASE_ADDR;
      words_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      words_q  <= words_d;
      err_q    <= err_d;
    end
  end

  // FIFO storage; contents are only observable through a valid occupancy
  always_ff @(posedge clk) begin
    if (push_c) fifo_q[wr_ptr_q] <= enc_c;
  end

  assign req_ready     = ~full_c;
  assign mem_we        = (count_q != '0);
  assign mem_wdata     = mem_we ? fifo_q[rd_ptr_q] : 32'h0;
  assign mem_addr      = addr_q;
  assign fifo_count    = count_q;
  assign words_written = words_q;
  assign err_illegal   = err_q;

endmodule

// File: doc/instr_stream_encoder.md
Name: instr_stream_encoder

Overview:
Inverse of the main control decode path. Accepts symbolic instruction requests (instruction class, register indices, funct bits, immediate) over a valid/ready handshake. Packs each request into a 32-bit RV32I word using the opcodes and immediate formats the core decodes. Buffers encoded words in a small FIFO and writes them sequentially into instruction memory, for bench program loading and boot-time code generation.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
ADDR_W, 32, instruction-memory address width
BASE_ADDR, 0, first write address after reset or clear; word aligned

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
clear  in  1  synchronous flush; returns the block to its post-reset state
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid and req_ready are both high
req_kind  in  4  0 LW, 1 SW, 2 R-type, 3 BRANCH, 4 I-type ALU, 5 JAL, 6 LUI, 7 AUIPC, 8 JALR; 9-15 illegal
req_funct3  in  3  funct3 for R, I-ALU, BRANCH; ignored otherwise
req_funct7b5  in  1  instr[30] for R-type and I-type shifts
req_rd  in  5  destination register
req_rs1  in  5  source register 1
req_rs2  in  5  source register 2
req_imm  in  32  immediate in byte-offset units, sign-extended
mem_we  out  1  write strobe
mem_addr  out  ADDR_W  write address
mem_wdata  out  32  encoded instruction
mem_ready  in  1  memory accepts the write this cycle
fifo_count  out  clog2(DEPTH)+1  occupancy
words_written  out  16  count of completed writes; saturates at 0xFFFF
err_illegal  out  1  sticky flag for a dropped request

Behaviour:
- Reset (async, reset_n=0) and clear (sync): FIFO empty; mem_we=0; mem_addr=BASE_ADDR; mem_wdata=0; fifo_count=0; words_written=0; err_illegal=0. req_ready=1 once reset_n is deasserted.
- Priority: reset_n > clear > push/pop. A request or write presented in a clear cycle is discarded.
- Handshake: req_ready = !full. There is no push-through-when-full bypass, even when a pop occurs in the same cycle.
- Encoding is combinational on request inputs. The encoded word is written into the FIFO on the accepting edge.
- Opcodes: LW 0000011, SW 0100011, R 0110011, BRANCH 1100011, I-ALU 0010011, JAL 1101111, LUI 0110111, AUIPC 0010111, JALR 1100111.
- funct3 forced to 010 for LW/SW and 000 for JALR. Unused fields (rd for SW/BRANCH, rs1/rs2 where absent) are encoded as 0.
- R-type: bits[31:25] = {0, funct7b5, 00000}.
- I-ALU with funct3 001 or 101: bits[31:25] = {0, funct7b5, 00000} and bits[24:20] = imm[4:0].
- Other I-type (I-ALU, LW, JALR): bits[31:20] = imm[11:0].
- S-format: imm[11:5] to [31:25], imm[4:0] to [11:7].
- B-format: imm[12], imm[10:5], imm[4:1], imm[11] to [31], [30:25], [11:8], [7].
- J-format: imm[20], imm[10:1], imm[11], imm[19:12] to [31], [30:21], [20], [19:12].
- U-format: imm[31:12] to [31:12].
- Upper immediate bits beyond each format's range are silently truncated.
- Illegal kind: request is accepted (req_ready honoured) but nothing is pushed; err_illegal is set on that edge and holds until reset or clear.
- Output side: mem_we = FIFO non-empty; mem_wdata = FIFO head; mem_addr = current write pointer.
- A write completes on a cycle with mem_we && mem_ready. On that edge: pop the FIFO; mem_addr += 4, wrapping modulo 2^ADDR_W; words_written increments.
- mem_wdata and mem_addr are held stable while mem_we=1 and mem_ready=0.
- Latency: request accepted at edge N means mem_we=1 with that word from edge N onward (1 cycle), provided the FIFO was empty.
- Simultaneous push and pop when not full: fifo_count is unchanged; order is preserved.
- Throughput: one word per cycle when mem_ready is held high.

Optional Feature:
INSTR_ENC_ALIGN_CHECK_EN
- Defined: a BRANCH or JAL request with req_imm[0]=1, or any request while mem_addr[1:0]≠0, is dropped like an illegal kind and sets err_illegal.
- Undefined: req_imm[0] is ignored and no alignment check is made.

Test Plan:
- I-ALU: kind=4, f3=000, rd=1, rs1=0, imm=5 -> mem_wdata=0x00500093 at mem_addr=BASE_ADDR, one cycle after accept.
- R-type: kind=2, f3=000, rd=3, rs1=1, rs2=2, f7b5=0 then f7b5=1 -> 0x002081B3 at addr 0, then 0x402081B3 at addr 4.
- S/B/J: sw rs1=1, rs2=2, imm=8 -> 0x0020A423; beq rs1=1, rs2=2, imm=-4 -> 0xFE208EE3; jal rd=1, imm=8 -> 0x008000EF; addresses 0, 4, 8.
- Backpressure: mem_ready=0, push 5 requests -> req_ready=0 after the 4th and the 5th stalls; set mem_ready=1 -> writes to 0x0, 0x4, 0x8, 0xC, 0x10 in order; words_written=5.
- Illegal kind: kind=12 -> accepted, no write, err_illegal=1; clear -> err_illegal=0, mem_addr=BASE_ADDR, fifo_count=0.
- Reset mid-stream: assert reset_n=0 asynchronously with 3 words queued -> mem_we drops immediately; after release, the next request writes to BASE_ADDR.
